// File: rtl/tcdm_mux_bridge.sv
// tcdm_mux_bridge
// Multi-channel eFPGA -> SoC TCDM request bridge. Each request channel has
// its own registered FIFO; a round-robin arbiter places one request at a
// time on the single TCDM master port, keeping at most MAX_OUTST
// transactions outstanding. A tag FIFO of channel IDs steers the in-order
// responses back to the channel that issued each request.
//
// Ports
//   i_soc_clk, i_soc_rst      clock, synchronous active-high reset
//   i_ch_req / i_ch_req_data  per-channel request strobe and {addr,be,wdata,wen}
//   o_ch_gnt / o_ch_fmo       per-channel FIFO not-full / almost-full
//   o_ch_valid / o_ch_rdata   per-channel one-cycle response pulse and data
//   o_tcdm_req / _req_data    SoC request and packet
//   i_tcdm_gnt                SoC accepts the current request
//   i_tcdm_valid / _rdata     SoC in-order response
//   o_outst_cnt               granted-but-unanswered transaction count
//   o_resp_err                sticky: response seen with nothing outstanding
module tcdm_mux_bridge #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_DEPTH  = 4,
  parameter int MAX_OUTST  = 4,
  parameter int AFULL_LVL  = 3,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int RW        = ADDR_WIDTH + BE_WIDTH + DATA_WIDTH + 1,
  localparam int OW        = $clog2(MAX_OUTST + 1)
) (
  input  logic                           i_soc_clk,
  input  logic                           i_soc_rst,
  input  logic [NUM_CH-1:0]              i_ch_req,
  input  logic [NUM_CH*RW-1:0]           i_ch_req_data,
  output logic [NUM_CH-1:0]              o_ch_gnt,
  output logic [NUM_CH-1:0]              o_ch_fmo,
  output logic [NUM_CH-1:0]              o_ch_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   o_ch_rdata,
  output logic                           o_tcdm_req,
  output logic [RW-1:0]                  o_tcdm_req_data,
  input  logic                           i_tcdm_gnt,
  input  logic                           i_tcdm_valid,
  input  logic [DATA_WIDTH-1:0]          i_tcdm_rdata,
  output logic [OW-1:0]                  o_outst_cnt,
  output logic                           o_resp_err
);

  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Request FIFOs: pointers carry one extra wrap bit so full != empty.
  logic [RW-1:0] r_fifo  [NUM_CH][REQ_DEPTH];
  logic [PW:0]   r_wptr  [NUM_CH];
  logic [PW:0]   r_rptr  [NUM_CH];
  logic [PW:0]   w_occ   [NUM_CH];

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_afull;

  // Arbitration state
  logic [CW-1:0] r_rr;
  logic          r_lock;
  logic [CW-1:0] r_lock_ch;
  logic [CW:0]   w_sum;
  logic          w_found;
  logic [CW-1:0] w_srch;
  logic [CW-1:0] w_win;
  logic          w_req;
  logic          w_grant;

  // Outstanding tracking; the tag FIFO occupancy always equals r_outst.
  logic [CW-1:0] r_tag [MAX_OUTST];
  logic [TW-1:0] r_tag_wp;
  logic [TW-1:0] r_tag_rp;
  logic [OW-1:0] r_outst;
  logic          w_at_max;
  logic          w_resp;
  logic [NUM_CH-1:0] w_tag_oh;

  logic [NUM_CH-1:0]            r_ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] r_ch_rdata;
  logic                         r_resp_err;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_at_max = (r_outst == OW'(MAX_OUTST));
  assign w_resp   = i_tcdm_valid & (r_outst != '0);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_occ[c]   = r_wptr[c] - r_rptr[c];
      w_empty[c] = (w_occ[c] == '0);
      w_full[c]  = (w_occ[c] == (PW+1)'(REQ_DEPTH));
      w_afull[c] = (w_occ[c] >= (PW+1)'(AFULL_LVL));
      w_elig[c]  = !w_empty[c] & !w_at_max;
      w_push[c]  = i_ch_req[c] & !w_full[c] & !i_soc_rst;
    end
  end

  // First eligible channel at or above the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_srch  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, r_rr} + (CW+1)'(k);
      if (w_sum >= (CW+1)'(NUM_CH)) w_sum = w_sum - (CW+1)'(NUM_CH);
      if (!w_found && w_elig[w_sum[CW-1:0]]) begin
        w_found = 1'b1;
        w_srch  = w_sum[CW-1:0];
      end
    end
  end

  // A request left waiting for tcdm_gnt keeps its channel; the locked
  // channel cannot lose eligibility since only a grant pops it or raises
  // the outstanding count.
  assign w_win   = r_lock ? r_lock_ch : w_srch;
  assign w_req   = !i_soc_rst & (r_lock | w_found);
  assign w_grant = w_req & i_tcdm_gnt;

  always_comb begin
    w_pop = '0;
    if (w_grant) w_pop[w_win] = 1'b1;
  end

  always_comb begin
    w_tag_oh = '0;
    if (w_resp) w_tag_oh[r_tag[r_tag_rp]] = 1'b1;
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge i_soc_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) r_fifo[c][r_wptr[c][PW-1:0]] <= i_ch_req_data[c*RW +: RW];
    end
    if (w_grant) r_tag[r_tag_wp] <= w_win;
  end

  always_ff @(posedge i_soc_clk) begin
    if (i_soc_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
      r_outst    <= '0;
      r_ch_valid <= '0;
      r_ch_rdata <= '0;
      r_resp_err <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
      end

      r_lock    <= w_req & !i_tcdm_gnt;
      r_lock_ch <= w_win;

      if (w_grant) begin
        r_rr     <= (w_win == CW'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
        r_tag_wp <= tag_inc(r_tag_wp);
      end
      if (w_resp) r_tag_rp <= tag_inc(r_tag_rp);

      case ({w_grant, w_resp})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase

      r_ch_valid <= w_tag_oh;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_tag_oh[c]) r_ch_rdata[c*DATA_WIDTH +: DATA_WIDTH] <= i_tcdm_rdata;
      end

      if (i_tcdm_valid && r_outst == '0) r_resp_err <= 1'b1;
    end
  end

  assign o_ch_gnt        = ~w_full & {NUM_CH{!i_soc_rst}};
  assign o_ch_fmo        = w_afull & {NUM_CH{!i_soc_rst}};
  assign o_tcdm_req      = w_req;
  assign o_tcdm_req_data = w_req ? r_fifo[w_win][r_rptr[w_win][PW-1:0]] : '0;
  assign o_ch_valid      = r_ch_valid;
  assign o_ch_rdata      = r_ch_rdata;
  assign o_outst_cnt     = r_outst;
  assign o_resp_err      = r_resp_err;

endmodule

// File: tb/tb_tcdm_mux_bridge.sv
// Testbench for tcdm_mux_bridge: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_tcdm_mux_bridge;
  localparam int N     = 4;
  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int RW    = AW + BW + DW + 1;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam int AFULL = 3;

  typedef logic [RW-1:0] pkt_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   ch_req;
  logic [N*RW-1:0] ch_req_data;
  logic [N-1:0]   ch_gnt, ch_fmo, ch_valid;
  logic [N*DW-1:0] ch_rdata;
  logic           tcdm_req;
  pkt_t           tcdm_req_data;
  logic           tcdm_gnt, tcdm_valid;
  logic [DW-1:0]  tcdm_rdata;
  logic [2:0]     outst_cnt;
  logic           resp_err;

  always #5 clk = ~clk;

  tcdm_mux_bridge #(
    .NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .REQ_DEPTH(DEPTH), .MAX_OUTST(MAXO), .AFULL_LVL(AFULL)
  ) dut (
    .i_soc_clk(clk), .i_soc_rst(rst),
    .i_ch_req(ch_req), .i_ch_req_data(ch_req_data),
    .o_ch_gnt(ch_gnt), .o_ch_fmo(ch_fmo),
    .o_ch_valid(ch_valid), .o_ch_rdata(ch_rdata),
    .o_tcdm_req(tcdm_req), .o_tcdm_req_data(tcdm_req_data),
    .i_tcdm_gnt(tcdm_gnt), .i_tcdm_valid(tcdm_valid), .i_tcdm_rdata(tcdm_rdata),
    .o_outst_cnt(outst_cnt), .o_resp_err(resp_err)
  );

  // Reference model: FIFO contents as queues, outstanding tags as a queue.
  pkt_t          mq [N][$];
  int            tagq [$];
  int            rr;
  int            held;
  logic [N-1:0]  mpulse;
  logic [DW-1:0] mrdata [N];
  logic          merr;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic pkt_t rand_pkt();
    return pkt_t'({$urandom(), $urandom()});
  endfunction

  function automatic bit pending();
    bit p = (tagq.size() > 0);
    for (int c = 0; c < N; c++) if (mq[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      mrdata[c] = '0;
    end
    tagq.delete();
    rr = 0;
    held = -1;
    mpulse = '0;
    merr = 1'b0;
  endtask

  task automatic push(input int c, input pkt_t p);
    ch_req[c] = 1'b1;
    ch_req_data[c*RW +: RW] = p;
  endtask

  // One clock cycle: compare outputs with the model, advance the model with
  // the applied inputs, clock the DUT, then drop pulse-type inputs.
  task automatic step();
    int win;
    int t;
    logic [N-1:0] gexp, fexp;
    #1;
    for (int c = 0; c < N; c++) begin
      gexp[c] = !rst && (mq[c].size() < DEPTH);
      fexp[c] = !rst && (mq[c].size() >= AFULL);
    end
    win = -1;
    if (!rst) begin
      if (held >= 0) win = held;
      else if (tagq.size() < MAXO)
        for (int k = 0; k < N; k++)
          if (win < 0 && mq[(rr + k) % N].size() > 0) win = (rr + k) % N;
    end
    chk("ch_gnt", ch_gnt, gexp);
    chk("ch_fmo", ch_fmo, fexp);
    chk("tcdm_req", tcdm_req, win >= 0);
    if (win >= 0) chk("tcdm_req_data", tcdm_req_data, mq[win][0]);
    if (!rst) chk("outst_cnt", outst_cnt, tagq.size());
    chk("ch_valid", ch_valid, mpulse);
    for (int c = 0; c < N; c++) chk($sformatf("ch_rdata%0d", c), ch_rdata[c*DW +: DW], mrdata[c]);
    chk("resp_err", resp_err, merr);

    if (rst) begin
      model_reset();
    end else begin
      mpulse = '0;
      if (tcdm_valid) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          mpulse[t] = 1'b1;
          mrdata[t] = tcdm_rdata;
        end else begin
          merr = 1'b1;
        end
      end
      if (win >= 0) begin
        if (tcdm_gnt) begin
          void'(mq[win].pop_front());
          tagq.push_back(win);
          rr = (win + 1) % N;
          held = -1;
        end else begin
          held = win;
        end
      end
      for (int c = 0; c < N; c++)
        if (ch_req[c] && gexp[c]) mq[c].push_back(ch_req_data[c*RW +: RW]);
    end
    @(posedge clk);
    #1;
    ch_req = '0;
    tcdm_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    tcdm_gnt = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!pending()) break;
      if (tagq.size() > 0) begin
        tcdm_valid = 1'b1;
        tcdm_rdata = $urandom();
      end
      step();
    end
    #1;
    chk("drain_outst", outst_cnt, 0);
  endtask

  pkt_t p1, p2, p1b;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    ch_req = '0;
    ch_req_data = '0;
    tcdm_gnt = 1'b0;
    tcdm_valid = 1'b0;
    tcdm_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_gnt", ch_gnt, 4'hF);
    chk("rst_req", tcdm_req, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_valid", ch_valid, 0);

    // Single ch0 write, gnt tied high.
    p1 = {20'h00010, 4'hF, 32'hDEADBEEF, 1'b1};
    tcdm_gnt = 1'b1;
    push(0, p1);
    step();
    #1;
    chk("t1_req", tcdm_req, 1);
    chk("t1_data", tcdm_req_data, p1);
    step();
    step();
    tcdm_valid = 1'b1;
    tcdm_rdata = 32'h1234_5678;
    step();
    #1;
    chk("t1_valid", ch_valid, 4'b0001);
    chk("t1_rdata", ch_rdata[DW-1:0], 32'h1234_5678);
    chk("t1_outst", outst_cnt, 0);
    step();

    // Four simultaneous reads after a fresh reset: grants ch0..ch3.
    rst = 1'b1;
    step();
    for (int c = 0; c < N; c++) push(c, {rand_pkt() >> 1, 1'b0});
    step();
    repeat (4) step();
    for (int i = 0; i < N; i++) begin
      tcdm_valid = 1'b1;
      tcdm_rdata = 32'hA0 + i;
      step();
      #1;
      chk("t2_valid", ch_valid, 4'b0001 << i);
      chk("t2_rdata", ch_rdata[i*DW +: DW], 32'hA0 + i);
    end
    drain();

    // Lock: ch2 waits on gnt while ch1 arrives.
    p2  = rand_pkt();
    p1b = rand_pkt();
    tcdm_gnt = 1'b0;
    push(2, p2);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) push(1, p1b);
      step();
      #1;
      chk("t3_lock_data", tcdm_req_data, p2);
    end
    tcdm_gnt = 1'b1;
    step();
    #1;
    chk("t3_next", tcdm_req_data, p1b);
    drain();

    // Outstanding limit.
    tcdm_gnt = 1'b1;
    for (int c = 0; c < N; c++) push(c, rand_pkt());
    step();
    push(0, rand_pkt());
    push(1, rand_pkt());
    step();
    repeat (5) step();
    #1;
    chk("t4_outst_max", outst_cnt, 4);
    chk("t4_req_off", tcdm_req, 0);
    tcdm_valid = 1'b1;
    tcdm_rdata = $urandom();
    step();
    #1;
    chk("t4_req_back", tcdm_req, 1);
    drain();

    // Fill ch3 with no grant.
    tcdm_gnt = 1'b0;
    for (int p = 0; p < 5; p++) begin
      push(3, rand_pkt());
      step();
      #1;
      chk("t5_fmo3", ch_fmo[3], p >= 2);
      chk("t5_gnt3", ch_gnt[3], p < 3);
    end
    drain();

    // Randomized traffic with one reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      ch_req = N'($urandom());
      for (int c = 0; c < N; c++) ch_req_data[c*RW +: RW] = rand_pkt();
      tcdm_gnt = ($urandom_range(0, 3) != 0);
      if (tagq.size() > 0 && $urandom_range(0, 1) == 1) begin
        tcdm_valid = 1'b1;
        tcdm_rdata = $urandom();
      end
      if (i == 200) rst = 1'b1;
      step();
    end
    drain();

    // Spurious response, then reset with data in flight.
    tcdm_valid = 1'b1;
    tcdm_rdata = 32'hBAD0_0001;
    step();
    #1;
    chk("t6_err", resp_err, 1);
    chk("t6_no_valid", ch_valid, 0);
    step();
    tcdm_gnt = 1'b0;
    push(0, rand_pkt());
    step();
    rst = 1'b1;
    step();
    #1;
    chk("t6_gnt_after", ch_gnt, 4'hF);
    chk("t6_err_clr", resp_err, 0);
    chk("t6_fmo", ch_fmo, 0);
    chk("t6_outst", outst_cnt, 0);
    step();
    tcdm_valid = 1'b1;
    step();
    #1;
    chk("t6_err_post", resp_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tcdm_mux_bridge.md
Name: tcdm_mux_bridge

Overview:
- Parametrised, single-clock successor to the eFPGA TCDM request/response bridge.
- Accepts NUM_CH independent eFPGA-side request channels, each buffered in its own request FIFO.
- Round-robin arbitrates the channels onto one SoC TCDM master port, with a bounded number of outstanding transactions.
- Routes in-order responses back to the originating channel through a channel-ID tag FIFO.

Parameters:
- NUM_CH, 4: number of eFPGA request channels (1..8).
- ADDR_WIDTH, 20: word address width.
- DATA_WIDTH, 32: data width. BE_WIDTH = DATA_WIDTH/8.
- REQ_DEPTH, 4: per-channel request FIFO depth. Power of two, >=2.
- MAX_OUTST, 4: maximum granted-but-unanswered transactions. Also the tag FIFO depth.
- AFULL_LVL, 3: FIFO occupancy at or above which ch_fmo asserts (1..REQ_DEPTH).

Ports:
- soc_clk  in  1  sole clock.
- soc_rst  in  1  reset.
- ch_req  in  NUM_CH  per-channel request strobe.
- ch_req_data  in  NUM_CH*RW  per-channel packet {addr,be,wdata,wen}. RW = ADDR_WIDTH+BE_WIDTH+DATA_WIDTH+1. Channel i occupies bits [i*RW +: RW].
- ch_gnt  out  NUM_CH  channel FIFO not full.
- ch_fmo  out  NUM_CH  channel FIFO almost full.
- ch_valid  out  NUM_CH  one-cycle response pulse to the channel.
- ch_rdata  out  NUM_CH*DATA_WIDTH  response data, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- tcdm_req  out  1  SoC request.
- tcdm_req_data  out  RW  packet presented with tcdm_req.
- tcdm_gnt  in  1  SoC accepts the current request.
- tcdm_valid  in  1  SoC response (one per granted request, in order, reads and writes).
- tcdm_rdata  in  DATA_WIDTH  response data.
- outst_cnt  out  clog2(MAX_OUTST+1)  current outstanding count.
- resp_err  out  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - All FIFOs empty, round-robin pointer 0, outstanding count 0.
  - tcdm_req=0, ch_valid=0, ch_rdata=0, resp_err=0, outst_cnt=0, ch_fmo=0.
  - ch_gnt is forced to 0 while soc_rst is high and returns to 1 on the first cycle after reset.
- Push: a packet is pushed into channel i when ch_req[i] & ch_gnt[i]. ch_gnt[i] = !full[i] & !soc_rst.
- ch_fmo[i] = (occupancy[i] >= AFULL_LVL).
- FIFOs are registered, not fall-through. A packet pushed at cycle t is eligible for arbitration no earlier than t+1.
- Arbitration: a channel is eligible when its FIFO is non-empty and outst_cnt < MAX_OUTST.
  - Winner = first eligible channel searching upward from the rr pointer, with wrap-around.
  - tcdm_req = 1 whenever a winner exists.
  - tcdm_req_data = head of the winner's FIFO.
- Lock: once tcdm_req is asserted without tcdm_gnt, the winner and data are held stable until tcdm_gnt. New arrivals on other channels do not change the selection.
- Grant, on tcdm_req & tcdm_gnt:
  - Pop the winner's FIFO.
  - Push the winner's ID into the tag FIFO.
  - Increment outst_cnt.
  - rr pointer = winner+1 mod NUM_CH.
  - Back-to-back grants are allowed every cycle.
- Response, on tcdm_valid with tag FIFO non-empty:
  - Pop the tag.
  - Next cycle: ch_valid[tag]=1 for exactly one cycle, and ch_rdata for that channel = the registered tcdm_rdata.
  - Other channels' ch_rdata hold their previous values.
  - Latency from tcdm_valid to ch_valid is 1 cycle.
- Simultaneous grant and response in one cycle: outst_cnt is unchanged, and the tag push and pop both occur.
- tcdm_valid with outst_cnt==0 is dropped (no ch_valid) and sets resp_err. resp_err clears only on reset.
- Outstanding limit: at outst_cnt==MAX_OUTST, tcdm_req deasserts.
  - A held (locked) request is never pending here, because the lock only forms when eligible.
  - A response in the same cycle re-enables arbitration from the next cycle.
- Push into a full FIFO is impossible by construction, since ch_gnt=0. ch_req while full is ignored and is not an error.
- Reset mid-operation: all in-flight state is discarded and responses arriving after reset set resp_err.
- Pointer arithmetic wraps modulo depth. An extra wrap bit distinguishes full from empty.

Test Plan:
- Reset, then a single ch0 write (addr 0x00010, be 0xF, wdata 0xDEADBEEF) with tcdm_gnt tied high -> tcdm_req at cycle t+1 with the same packet. A tcdm_valid 2 cycles later -> ch_valid[0] one-cycle pulse 1 cycle later, outst_cnt returns 0.
- All 4 channels push one read each in the same cycle, tcdm_gnt=1 -> grant order ch0,ch1,ch2,ch3 on consecutive cycles. Responses with rdata 0xA0..0xA3 -> ch_valid pulses on ch0..ch3 in order with the matching data.
- tcdm_gnt held 0 for 5 cycles while ch2 has data and ch1 then pushes -> tcdm_req_data stays ch2's packet throughout. On gnt, ch1 is granted next.
- Hold tcdm_valid=0, issue 6 requests with MAX_OUTST=4 -> 4 grants, then tcdm_req=0, outst_cnt=4. One tcdm_valid -> the 5th grant follows on the next cycle.
- Fill ch3 with 4 pushes and no gnt -> ch_fmo[3]=1 after the 3rd push, ch_gnt[3]=0 after the 4th. A 5th ch_req is ignored and the FIFO contents are unchanged.
- tcdm_valid pulse with outst_cnt=0 -> no ch_valid and resp_err=1 held. Asserting soc_rst for 1 cycle -> resp_err=0, FIFOs empty, ch_gnt=0 during reset and all 1s the cycle after.
